// File: rtl/alpaca_dtypes_pkg.sv
// Shared types and width defaults for the parallel XFFT run-time control path.
package alpaca_dtypes_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CFG   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } xfft_ctrl_state_t;

  localparam int XFFT_CONF_WID = 16;
  localparam int XFFT_STAT_WID = 8;
  localparam int XFFT_CNT_WID  = 16;

  function automatic logic [1:0] popcount2(input logic [1:0] s);
    return (s[1] & s[0]) ? 2'd2 : {1'b0, s[1] | s[0]};
  endfunction

endpackage

// File: rtl/sat_event_cnt.sv
// Saturating counter of a two-lane event strobe; adds 0, 1 or 2 per cycle.
module sat_event_cnt
  import alpaca_dtypes_pkg::*;
#(
  parameter int CNT_WID = XFFT_CNT_WID
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [1:0]         strobe,
  output logic [CNT_WID-1:0] cnt
);

  logic [CNT_WID:0] sum;

  // One spare bit catches the carry out; any carry means the count is past full scale.
  always_comb begin
    sum = {1'b0, cnt} + {{(CNT_WID-1){1'b0}}, popcount2(strobe)};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (sum[CNT_WID]) begin
      cnt <= '1;
    end else begin
      cnt <= sum[CNT_WID-1:0];
    end
  end

endmodule

// File: rtl/xfft_cfg_ctrl.sv
// Run-time controller for the two-lane XFFT: config sequencing, frame-aligned
// input gating, status capture and event counting.
//
// state | meaning
// LOAD  | latch both config words, input gate closed
// CFG   | config tvalids up until each channel handshakes, gate closed
// RUN   | gate open, waiting for cfg_apply
// DRAIN | gate open until the last beat of the current frame transfers
module xfft_cfg_ctrl
  import alpaca_dtypes_pkg::*;
#(
  parameter int FFT_LEN      = 2048,
  parameter int FFT_CONF_WID = XFFT_CONF_WID,
  parameter int FFT_STAT_WID = XFFT_STAT_WID,
  parameter int CNT_WID      = XFFT_CNT_WID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FFT_CONF_WID-1:0] cfg_x2_word,
  input  logic [FFT_CONF_WID-1:0] cfg_x1_word,
  input  logic                    cfg_apply,
  output logic                    cfg_busy,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [FFT_CONF_WID-1:0] m_axis_cfg_x2_tdata,
  output logic                    m_axis_cfg_x2_tvalid,
  input  logic                    m_axis_cfg_x2_tready,
  output logic [FFT_CONF_WID-1:0] m_axis_cfg_x1_tdata,
  output logic                    m_axis_cfg_x1_tvalid,
  input  logic                    m_axis_cfg_x1_tready,
  input  logic [FFT_STAT_WID-1:0] s_axis_stat_x2_tdata,
  input  logic                    s_axis_stat_x2_tvalid,
  output logic                    s_axis_stat_x2_tready,
  input  logic [FFT_STAT_WID-1:0] s_axis_stat_x1_tdata,
  input  logic                    s_axis_stat_x1_tvalid,
  output logic                    s_axis_stat_x1_tready,
  output logic [FFT_STAT_WID-1:0] stat_x2,
  output logic [FFT_STAT_WID-1:0] stat_x1,
  input  logic [1:0]              event_tlast_unexpected,
  input  logic [1:0]              event_tlast_missing,
  input  logic [1:0]              event_fft_overflow,
  input  logic [1:0]              event_data_in_channel_halt,
  input  logic                    cnt_clr,
  output logic [CNT_WID-1:0]      cnt_tlast_unexp,
  output logic [CNT_WID-1:0]      cnt_tlast_miss,
  output logic [CNT_WID-1:0]      cnt_ovfl,
  output logic [CNT_WID-1:0]      cnt_halt,
  output logic                    frame_err
);

  localparam int FRAME_BEATS = FFT_LEN / 2;
  localparam int BEAT_WID    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [BEAT_WID-1:0] LAST_BEAT = BEAT_WID'(FRAME_BEATS - 1);

  xfft_ctrl_state_t state, state_nxt;

  logic [FFT_CONF_WID-1:0] word_x2, word_x1;
  logic                    done_x2, done_x1;
  logic [BEAT_WID-1:0]     beat_cnt;
  logic                    gate_open, beat_xfer, beat_last;
  logic                    hs_x2, hs_x1, latch_words;

  assign gate_open     = (state == ST_RUN) || (state == ST_DRAIN);
  assign m_axis_tvalid = gate_open & s_axis_tvalid;
  assign s_axis_tready = gate_open & m_axis_tready;
  assign beat_xfer     = gate_open & s_axis_tvalid & m_axis_tready;
  assign beat_last     = (beat_cnt == LAST_BEAT);

  assign m_axis_cfg_x2_tvalid = (state == ST_CFG) && !done_x2;
  assign m_axis_cfg_x1_tvalid = (state == ST_CFG) && !done_x1;
  assign m_axis_cfg_x2_tdata  = word_x2;
  assign m_axis_cfg_x1_tdata  = word_x1;
  assign hs_x2 = m_axis_cfg_x2_tvalid & m_axis_cfg_x2_tready;
  assign hs_x1 = m_axis_cfg_x1_tvalid & m_axis_cfg_x1_tready;

  assign cfg_busy = (state != ST_RUN);

  always_comb begin
    state_nxt   = state;
    latch_words = 1'b0;
    case (state)
      ST_LOAD: begin
        latch_words = 1'b1;
        state_nxt   = ST_CFG;
      end
      ST_CFG: begin
        if (done_x2 && done_x1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cfg_apply) begin
          latch_words = 1'b1;
          state_nxt   = (beat_cnt == '0 && !beat_xfer) ? ST_CFG : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat_xfer && beat_last) state_nxt = ST_CFG;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Done flags are held only while in CFG so every CFG entry starts a fresh write pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      word_x2   <= '0;
      word_x1   <= '0;
      done_x2   <= 1'b0;
      done_x1   <= 1'b0;
      beat_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_x2 <= (state == ST_CFG) && (done_x2 || hs_x2);
      done_x1 <= (state == ST_CFG) && (done_x1 || hs_x1);
      if (latch_words) begin
        word_x2 <= cfg_x2_word;
        word_x1 <= cfg_x1_word;
      end
      if (beat_xfer) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + BEAT_WID'(1);
      end
      if (cnt_clr) begin
        frame_err <= 1'b0;
      end else if (beat_xfer && (s_axis_tlast != beat_last)) begin
        frame_err <= 1'b1;
      end
    end
  end

  assign s_axis_stat_x2_tready = ~rst;
  assign s_axis_stat_x1_tready = ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_x2 <= '0;
      stat_x1 <= '0;
    end else begin
      if (s_axis_stat_x2_tvalid) stat_x2 <= s_axis_stat_x2_tdata;
      if (s_axis_stat_x1_tvalid) stat_x1 <= s_axis_stat_x1_tdata;
    end
  end

  sat_event_cnt #(.CNT_WID(CNT_WID)) u_cnt_unexp (
    .clk(clk), .rst(rst), .clr(cnt_clr), .strobe(event_tlast_unexpected), .cnt(cnt_tlast_unexp)
  );
  sat_event_cnt #(.CNT_WID(CNT_WID)) u_cnt_miss (
    .clk(clk), .rst(rst), .clr(cnt_clr), .strobe(event_tlast_missing), .cnt(cnt_tlast_miss)
  );
  sat_event_cnt #(.CNT_WID(CNT_WID)) u_cnt_ovfl (
    .clk(clk), .rst(rst), .clr(cnt_clr), .strobe(event_fft_overflow), .cnt(cnt_ovfl)
  );
  sat_event_cnt #(.CNT_WID(CNT_WID)) u_cnt_halt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .strobe(event_data_in_channel_halt), .cnt(cnt_halt)
  );

endmodule

// File: tb/tb_xfft_cfg_ctrl.sv
// Directed bench for xfft_cfg_ctrl; config writes and status captures are
// checked by a scoreboard monitor, timing points by direct checks.
`timescale 1ns/1ps
module tb_xfft_cfg_ctrl;
  localparam int FFT_LEN = 16;
  localparam int CW = 16;
  localparam int SW = 8;
  localparam int NW = 3;

  logic          clk, rst;
  logic [CW-1:0] cfg_x2_word, cfg_x1_word;
  logic          cfg_apply, cfg_busy;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready;
  logic [CW-1:0] m_axis_cfg_x2_tdata, m_axis_cfg_x1_tdata;
  logic          m_axis_cfg_x2_tvalid, m_axis_cfg_x2_tready;
  logic          m_axis_cfg_x1_tvalid, m_axis_cfg_x1_tready;
  logic [SW-1:0] s_axis_stat_x2_tdata, s_axis_stat_x1_tdata;
  logic          s_axis_stat_x2_tvalid, s_axis_stat_x2_tready;
  logic          s_axis_stat_x1_tvalid, s_axis_stat_x1_tready;
  logic [SW-1:0] stat_x2, stat_x1;
  logic [1:0]    ev_unexp, ev_miss, ev_ovfl, ev_halt;
  logic          cnt_clr;
  logic [NW-1:0] cnt_tlast_unexp, cnt_tlast_miss, cnt_ovfl, cnt_halt;
  logic          frame_err;

  xfft_cfg_ctrl #(.FFT_LEN(FFT_LEN), .FFT_CONF_WID(CW), .FFT_STAT_WID(SW), .CNT_WID(NW)) dut (
    .clk(clk), .rst(rst),
    .cfg_x2_word(cfg_x2_word), .cfg_x1_word(cfg_x1_word),
    .cfg_apply(cfg_apply), .cfg_busy(cfg_busy),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_cfg_x2_tdata(m_axis_cfg_x2_tdata), .m_axis_cfg_x2_tvalid(m_axis_cfg_x2_tvalid),
    .m_axis_cfg_x2_tready(m_axis_cfg_x2_tready),
    .m_axis_cfg_x1_tdata(m_axis_cfg_x1_tdata), .m_axis_cfg_x1_tvalid(m_axis_cfg_x1_tvalid),
    .m_axis_cfg_x1_tready(m_axis_cfg_x1_tready),
    .s_axis_stat_x2_tdata(s_axis_stat_x2_tdata), .s_axis_stat_x2_tvalid(s_axis_stat_x2_tvalid),
    .s_axis_stat_x2_tready(s_axis_stat_x2_tready),
    .s_axis_stat_x1_tdata(s_axis_stat_x1_tdata), .s_axis_stat_x1_tvalid(s_axis_stat_x1_tvalid),
    .s_axis_stat_x1_tready(s_axis_stat_x1_tready),
    .stat_x2(stat_x2), .stat_x1(stat_x1),
    .event_tlast_unexpected(ev_unexp), .event_tlast_missing(ev_miss),
    .event_fft_overflow(ev_ovfl), .event_data_in_channel_halt(ev_halt),
    .cnt_clr(cnt_clr),
    .cnt_tlast_unexp(cnt_tlast_unexp), .cnt_tlast_miss(cnt_tlast_miss),
    .cnt_ovfl(cnt_ovfl), .cnt_halt(cnt_halt),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [CW-1:0] word;
    int            beats;
  } cfg_exp_t;

  cfg_exp_t      q_x2[$], q_x1[$];
  logic [SW-1:0] q_sx2[$], q_sx1[$];
  int            n_tests = 0, n_fail = 0;
  int            mon_beats = 0;
  logic [31:0]   src_id = 0;
  logic          src_fire = 0;
  logic          unexp_en = 0, miss_en = 0;
  logic          pend_x2 = 0, pend_x1 = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  // Upstream source: beat ids count transfers, tlast on the 8th beat of each frame.
  assign s_axis_tlast = s_axis_tvalid &&
    ((src_id[2:0] == 3'd7 && !miss_en) || (unexp_en && src_id[2:0] == 3'd4));
  always @(negedge clk) src_fire = s_axis_tvalid && s_axis_tready;
  always @(posedge clk) if (src_fire) src_id <= src_id + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cfg_exp_t e;
    if (m_axis_cfg_x2_tvalid && m_axis_cfg_x2_tready) begin
      if (q_x2.size() == 0) chk("x2 write unexpected", 32'(m_axis_cfg_x2_tdata), 32'hFFFF_FFFF);
      else begin
        e = q_x2.pop_front();
        chk("x2 write word", 32'(m_axis_cfg_x2_tdata), 32'(e.word));
        chk("x2 write beat position", mon_beats, e.beats);
      end
    end
    if (m_axis_cfg_x1_tvalid && m_axis_cfg_x1_tready) begin
      if (q_x1.size() == 0) chk("x1 write unexpected", 32'(m_axis_cfg_x1_tdata), 32'hFFFF_FFFF);
      else begin
        e = q_x1.pop_front();
        chk("x1 write word", 32'(m_axis_cfg_x1_tdata), 32'(e.word));
        chk("x1 write beat position", mon_beats, e.beats);
      end
    end
    if (m_axis_tvalid && m_axis_tready) mon_beats++;
    if (pend_x2) begin
      if (q_sx2.size() == 0) chk("stat_x2 unexpected", 32'(stat_x2), 32'hFFFF_FFFF);
      else chk("stat_x2 capture", 32'(stat_x2), 32'(q_sx2.pop_front()));
    end
    if (pend_x1) begin
      if (q_sx1.size() == 0) chk("stat_x1 unexpected", 32'(stat_x1), 32'hFFFF_FFFF);
      else chk("stat_x1 capture", 32'(stat_x1), 32'(q_sx1.pop_front()));
    end
    pend_x2 = s_axis_stat_x2_tvalid && s_axis_stat_x2_tready;
    pend_x1 = s_axis_stat_x1_tvalid && s_axis_stat_x1_tready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cfg(input logic [CW-1:0] w2, input logic [CW-1:0] w1, input int beats);
    cfg_exp_t e;
    e.word = w2; e.beats = beats; q_x2.push_back(e);
    e.word = w1; e.beats = beats; q_x1.push_back(e);
  endtask

  task automatic stop_at_boundary();
    int n = 0;
    while (src_id[2:0] != 3'd0 && n < 40) begin
      tick();
      n++;
    end
    chk("source reached frame boundary", 32'(src_id[2:0]), 32'd0);
    s_axis_tvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; cfg_apply = 0; cnt_clr = 0;
    cfg_x2_word = 16'h0155; cfg_x1_word = 16'h0001;
    s_axis_tvalid = 0; m_axis_tready = 1;
    m_axis_cfg_x2_tready = 1; m_axis_cfg_x1_tready = 1;
    s_axis_stat_x2_tdata = 0; s_axis_stat_x2_tvalid = 0;
    s_axis_stat_x1_tdata = 0; s_axis_stat_x1_tvalid = 0;
    ev_unexp = 0; ev_miss = 0; ev_ovfl = 0; ev_halt = 0;
    repeat (3) tick();

    // Reset values
    chk("reset cfg_busy", 32'(cfg_busy), 1);
    chk("reset x2 tvalid", 32'(m_axis_cfg_x2_tvalid), 0);
    chk("reset x1 tvalid", 32'(m_axis_cfg_x1_tvalid), 0);
    chk("reset s_axis_tready", 32'(s_axis_tready), 0);
    chk("reset stat tready", 32'({s_axis_stat_x2_tready, s_axis_stat_x1_tready}), 0);
    chk("reset stat words", 32'({stat_x2, stat_x1}), 0);
    chk("reset counters", 32'({cnt_tlast_unexp, cnt_tlast_miss, cnt_ovfl, cnt_halt}), 0);
    chk("reset frame_err", 32'(frame_err), 0);

    // Reset release: LOAD then CFG, gate opens two cycles after CFG entry
    push_cfg(16'h0155, 16'h0001, 0);
    rst = 0;
    tick();
    chk("release x2 tvalid up", 32'(m_axis_cfg_x2_tvalid), 1);
    chk("release x1 tvalid up", 32'(m_axis_cfg_x1_tvalid), 1);
    chk("stat tready after reset", 32'({s_axis_stat_x2_tready, s_axis_stat_x1_tready}), 32'h3);
    tick();
    chk("release tvalids down", 32'({m_axis_cfg_x2_tvalid, m_axis_cfg_x1_tvalid}), 0);
    chk("release busy in CFG", 32'(cfg_busy), 1);
    chk("release gate closed", 32'(s_axis_tready), 0);
    tick();
    chk("release busy falls", 32'(cfg_busy), 0);
    chk("release gate open", 32'(s_axis_tready), 1);

    // Mid-frame reconfigure at beat 3, frame of 8 beats
    s_axis_tvalid = 1;
    repeat (3) tick();
    cfg_x2_word = 16'h0AAA; cfg_x1_word = 16'h0333; cfg_apply = 1;
    push_cfg(16'h0AAA, 16'h0333, 8);
    tick();
    cfg_apply = 0;
    chk("drain busy", 32'(cfg_busy), 1);
    chk("drain gate open", 32'(m_axis_tvalid), 1);
    cfg_x2_word = 16'h0BAD; cfg_x1_word = 16'h0BAD; cfg_apply = 1;
    tick();
    cfg_apply = 0;
    tick(); tick();
    chk("drain still open at beat 7", 32'(m_axis_tvalid), 1);
    tick();
    chk("drain beats passed", src_id, 8);
    chk("drain gate closed m_tvalid", 32'(m_axis_tvalid), 0);
    chk("drain gate closed s_tready", 32'(s_axis_tready), 0);
    tick(); tick();
    chk("reconfig back in RUN", 32'(cfg_busy), 0);
    chk("reconfig frame_err clear", 32'(frame_err), 0);
    stop_at_boundary();

    // Skewed config ready on x1, applied at a frame boundary with no traffic
    m_axis_cfg_x1_tready = 0;
    cfg_x2_word = 16'h0011; cfg_x1_word = 16'h0022; cfg_apply = 1;
    push_cfg(16'h0011, 16'h0022, int'(src_id));
    tick();
    cfg_apply = 0;
    chk("skew both tvalid", 32'({m_axis_cfg_x2_tvalid, m_axis_cfg_x1_tvalid}), 32'h3);
    tick();
    chk("skew x2 tvalid dropped", 32'(m_axis_cfg_x2_tvalid), 0);
    for (int i = 0; i < 5; i++) begin
      chk("skew x1 tvalid held", 32'(m_axis_cfg_x1_tvalid), 1);
      if (i < 4) tick();
    end
    m_axis_cfg_x1_tready = 1;
    tick();
    chk("skew x1 tvalid dropped", 32'(m_axis_cfg_x1_tvalid), 0);
    chk("skew busy until x1 done", 32'(cfg_busy), 1);
    tick();
    chk("skew RUN after x1", 32'(cfg_busy), 0);

    // Frame check: unexpected tlast at beat 4, then missing tlast
    s_axis_tvalid = 1; unexp_en = 1;
    repeat (4) tick();
    chk("frame_err before bad tlast", 32'(frame_err), 0);
    tick();
    chk("frame_err on early tlast", 32'(frame_err), 1);
    unexp_en = 0;
    repeat (11) tick();
    chk("frame_err sticky", 32'(frame_err), 1);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    chk("frame_err cleared", 32'(frame_err), 0);
    miss_en = 1;
    repeat (8) tick();
    miss_en = 0;
    chk("frame_err on missing tlast", 32'(frame_err), 1);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    chk("frame_err cleared again", 32'(frame_err), 0);
    stop_at_boundary();

    // Event counters, saturating at 7
    ev_ovfl = 2'b11; ev_unexp = 2'b01;
    repeat (3) tick();
    ev_ovfl = 0; ev_unexp = 0;
    chk("cnt_ovfl after 3x2", 32'(cnt_ovfl), 6);
    chk("cnt_tlast_unexp after 3x1", 32'(cnt_tlast_unexp), 3);
    ev_ovfl = 2'b11; ev_miss = 2'b10; ev_halt = 2'b11;
    tick();
    ev_ovfl = 2'b01; ev_miss = 0; ev_halt = 0;
    chk("cnt_ovfl saturates", 32'(cnt_ovfl), 7);
    chk("cnt_tlast_miss single lane", 32'(cnt_tlast_miss), 1);
    chk("cnt_halt both lanes", 32'(cnt_halt), 2);
    tick();
    ev_ovfl = 2'b11; ev_halt = 2'b11; cnt_clr = 1;
    chk("cnt_ovfl holds at max", 32'(cnt_ovfl), 7);
    tick();
    ev_ovfl = 0; ev_halt = 0; cnt_clr = 0;
    chk("clear beats strobe ovfl", 32'(cnt_ovfl), 0);
    chk("clear beats strobe halt", 32'(cnt_halt), 0);
    chk("clear others", 32'({cnt_tlast_unexp, cnt_tlast_miss}), 0);

    // Status capture
    s_axis_stat_x2_tdata = 8'h5A; s_axis_stat_x2_tvalid = 1; q_sx2.push_back(8'h5A);
    s_axis_stat_x1_tdata = 8'hC3; s_axis_stat_x1_tvalid = 1; q_sx1.push_back(8'hC3);
    tick();
    s_axis_stat_x2_tdata = 8'h81; q_sx2.push_back(8'h81);
    s_axis_stat_x1_tvalid = 0; s_axis_stat_x1_tdata = 8'hFF;
    tick();
    s_axis_stat_x2_tvalid = 0; s_axis_stat_x2_tdata = 8'hEE;
    repeat (3) tick();
    chk("stat_x2 holds", 32'(stat_x2), 32'h81);
    chk("stat_x1 holds", 32'(stat_x1), 32'hC3);

    // Reset asserted during CFG, re-run with the words present at release
    m_axis_cfg_x2_tready = 0; m_axis_cfg_x1_tready = 0;
    cfg_x2_word = 16'h0777; cfg_x1_word = 16'h0888; cfg_apply = 1;
    tick();
    cfg_apply = 0;
    chk("pre-reset CFG tvalids", 32'({m_axis_cfg_x2_tvalid, m_axis_cfg_x1_tvalid}), 32'h3);
    rst = 1;
    cfg_x2_word = 16'h0999; cfg_x1_word = 16'h0AAB;
    tick();
    chk("reset drops tvalids", 32'({m_axis_cfg_x2_tvalid, m_axis_cfg_x1_tvalid}), 0);
    chk("reset clears stat", 32'({stat_x2, stat_x1}), 0);
    chk("reset busy", 32'(cfg_busy), 1);
    rst = 0;
    tick();
    chk("rerun CFG tvalids", 32'({m_axis_cfg_x2_tvalid, m_axis_cfg_x1_tvalid}), 32'h3);
    push_cfg(16'h0999, 16'h0AAB, mon_beats);
    m_axis_cfg_x2_tready = 1; m_axis_cfg_x1_tready = 1;
    tick(); tick();
    chk("rerun back in RUN", 32'(cfg_busy), 0);
    tick();

    chk("x2 writes all seen", q_x2.size(), 0);
    chk("x1 writes all seen", q_x1.size(), 0);
    chk("status captures all seen", q_sx2.size() + q_sx1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xfft_cfg_ctrl.md
# xfft_cfg_ctrl

Run-time controller for the two-lane parallel XFFT. It sits between the upstream polyphase sample stream and the `parallel_xfft` input. It sequences configuration writes to the x2 (N/2-point sub-FFT) and x1 (final-stage) config channels, and gates the input stream so that reconfiguration lands only on frame boundaries. It also consumes both FFT status channels and keeps saturating counters of the FFT event strobes for software.

## Interface

Parameters:
- `FFT_LEN`, 2048: full N-point FFT length; a frame is FFT_LEN/2 beats (2 samples/clk).
- `FFT_CONF_WID`, 16: config word width.
- `FFT_STAT_WID`, 8: status word width.
- `CNT_WID`, 16: event counter width.

Ports:
- `clk`  in  1: single clock; all logic is on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_x2_word`  in  FFT_CONF_WID: config word for the x2 channel.
- `cfg_x1_word`  in  FFT_CONF_WID: config word for the x1 channel.
- `cfg_apply`  in  1: single-cycle request to apply both words.
- `cfg_busy`  out  1: high from latch until both writes complete and the gate reopens.
- `s_axis_tvalid` / `s_axis_tready` / `s_axis_tlast`  in/out/in  1: upstream handshake; tdata bypasses this block.
- `m_axis_tvalid` / `m_axis_tready`  out/in  1: handshake toward the XFFT input.
- `m_axis_cfg_x2_tdata`, `_tvalid`, `_tready`  out/out/in  FFT_CONF_WID/1/1: x2 config channel.
- `m_axis_cfg_x1_tdata`, `_tvalid`, `_tready`  out/out/in: x1 config channel.
- `s_axis_stat_x2_tdata`, `_tvalid`, `_tready`  in/in/out  FFT_STAT_WID/1/1: x2 status channel.
- `s_axis_stat_x1_tdata`, `_tvalid`, `_tready`  in/in/out: x1 status channel.
- `stat_x2`, `stat_x1`  out  FFT_STAT_WID: last captured status word per lane.
- `event_tlast_unexpected`, `event_tlast_missing`, `event_fft_overflow`, `event_data_in_channel_halt`  in  2: per-lane event strobes.
- `cnt_clr`  in  1: synchronous clear of all counters.
- `cnt_tlast_unexp`, `cnt_tlast_miss`, `cnt_ovfl`, `cnt_halt`  out  CNT_WID: saturating counters.
- `frame_err`  out  1: sticky; set when a tlast arrives off a boundary or is missing at one. Cleared by `cnt_clr`.

## Operation

- The FSM has four states: LOAD, CFG, RUN, DRAIN.
- **LOAD** (the reset state):
  - Latch `cfg_x2_word` and `cfg_x1_word`; the gate is closed.
  - Next state is CFG.
- **CFG**:
  - Both config tvalids are asserted together with the latched words.
  - Each tvalid drops independently after its own handshake (tvalid&tready).
  - When both are done, go to RUN.
- **RUN**:
  - The gate is open: `m_axis_tvalid = s_axis_tvalid`, `s_axis_tready = m_axis_tready`.
  - On `cfg_apply`, latch both words and set `cfg_busy`.
    - If the beat counter is 0 and no beat transfers this cycle, go straight to CFG.
    - Otherwise go to DRAIN.
- **DRAIN**:
  - The gate stays open until the handshake with beat counter = FFT_LEN/2-1. That final beat transfers, and the FSM moves to CFG on the same edge.
- **Gate closed** (LOAD, CFG): `m_axis_tvalid = 0`, `s_axis_tready = 0`.
- **Beat counter**:
  - Increments on each transferred beat and wraps at FFT_LEN/2-1 → 0.
  - `frame_err` sets if `s_axis_tlast` is high with count ≠ FFT_LEN/2-1, or low with count = FFT_LEN/2-1.
  - The counter is not resynchronised to tlast.
- **`cfg_apply` outside RUN** is ignored. A new `cfg_apply` cannot be accepted until `cfg_busy` falls.
- **Status channels**:
  - tready is tied to 1 except under reset.
  - `stat_xN` is registered on tvalid.
- **Event counters**:
  - Each cycle a counter adds popcount of its 2-bit strobe (0, 1 or 2), saturating at 2^CNT_WID-1.
  - `cnt_clr` takes priority over increments in the same cycle.

## Timing

- **Reset values**:
  - State LOAD; `cfg_busy` = 1.
  - All tvalids = 0, `s_axis_tready` = 0.
  - `stat_x2`, `stat_x1`, all counters, `frame_err` and the beat counter = 0.
  - Status tready = 0.
- **Reset mid-operation**: abandons any pending config write (tvalid drops the next cycle) and re-runs LOAD→CFG using the current input words.
- **Config latency**:
  - Config tvalid rises 1 cycle after LOAD.
  - With tready held high on both channels, the gate opens 2 cycles after the CFG entry edge.
- **Handshake and data rules**:
  - Config tdata is stable while tvalid is high.
  - The gate path is combinational (zero latency).
  - Gate state changes only on clock edges, so a beat is never half-accepted.
- **Counter latency**: counters and status registers update 1 cycle after the strobe or handshake.

## Structure

- Shared package `alpaca_dtypes_pkg` holds:
  - The FSM state enum `xfft_ctrl_state_t`.
  - The config/status width constants.
- One sub-module, `sat_event_cnt` (2-bit strobe in, CNT_WID saturating count, clear), is instantiated four times.

## Test plan

- **Reset release**: hold tready=1 on both config channels, words 0x0155/0x0001. Expect config tvalids high on cycle 2, each accepted once with those words; `cfg_busy` falls and the gate opens 2 cycles after CFG entry.
- **Mid-frame reconfigure**: FFT_LEN=16, continuous traffic. Pulse `cfg_apply` at beat 3. Expect beats 3..7 to pass, then the gate to close; the new words are written; no beats are lost or duplicated and `frame_err` = 0.
- **Skewed config ready**: x1 tready delayed 5 cycles. Expect x2 tvalid to drop after 1 cycle, x1 tvalid held 6 cycles, and RUN only after x1 completes.
- **Frame check**: inject tlast at beat 4 of 8. Expect `frame_err` = 1 and sticky until `cnt_clr`.
- **Events**: strobe `event_fft_overflow` = 2'b11 for 3 cycles. Expect `cnt_ovfl` = 6. With CNT_WID=3, expect saturation at 7. `cnt_clr` coincident with a strobe yields 0.
- **Reset asserted during CFG**: expect config tvalids to drop next cycle and the full LOAD→CFG sequence to repeat.
